// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the mini-SRC hardwired control unit: opcodes,
// sequencer state encoding, instruction classes and the strobe bundle.
package cpu_ctrl_pkg;

    localparam int OPC_W   = 5;
    localparam int NSTEP_W = 4;

    localparam logic [OPC_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OPC_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPC_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPC_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OPC_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OPC_W-1:0] OP_ADDI = 5'b01100;
    localparam logic [OPC_W-1:0] OP_ANDI = 5'b01101;
    localparam logic [OPC_W-1:0] OP_ORI  = 5'b01110;
    localparam logic [OPC_W-1:0] OP_MUL  = 5'b01111;
    localparam logic [OPC_W-1:0] OP_DIV  = 5'b10000;
    localparam logic [OPC_W-1:0] OP_BR   = 5'b10010;
    localparam logic [OPC_W-1:0] OP_JR   = 5'b10011;
    localparam logic [OPC_W-1:0] OP_IN   = 5'b10110;
    localparam logic [OPC_W-1:0] OP_OUT  = 5'b10111;
    localparam logic [OPC_W-1:0] OP_MFLO = 5'b11000;
    localparam logic [OPC_W-1:0] OP_MFHI = 5'b11001;
    localparam logic [OPC_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

    typedef enum logic [NSTEP_W-1:0] {
        RESET_S, T0, T1, T2, T3, T4, T5, T6, T7, HALT
    } state_t;

    typedef enum logic [3:0] {
        CL_ALU, CL_IMM, CL_LDI, CL_MULDIV, CL_LD, CL_ST, CL_BR,
        CL_JR, CL_MFHI, CL_MFLO, CL_IN, CL_OUT, CL_NOP, CL_HALT
    } iclass_t;

    typedef struct packed {
        logic run;
        logic clear;
        logic pc_out;
        logic zhigh_out;
        logic zlow_out;
        logic mdr_out;
        logic hi_out;
        logic lo_out;
        logic inport_out;
        logic c_out;
        logic ba_out;
        logic pc_in;
        logic z_in;
        logic mdr_in;
        logic mar_in;
        logic y_in;
        logic hi_in;
        logic lo_in;
        logic ir_in;
        logic outport_in;
        logic con_in;
        logic gra;
        logic grb;
        logic grc;
        logic r_in;
        logic r_out;
        logic inc_pc;
        logic read;
        logic write;
    } ctrl_t;

    // Undefined opcodes fall into the nop class.
    function automatic iclass_t opc_class(input logic [OPC_W-1:0] opc);
        case (opc)
            OP_ADD, OP_SUB, OP_AND, OP_OR: opc_class = CL_ALU;
            OP_ADDI, OP_ANDI, OP_ORI:      opc_class = CL_IMM;
            OP_LDI:                        opc_class = CL_LDI;
            OP_MUL, OP_DIV:                opc_class = CL_MULDIV;
            OP_LD:                         opc_class = CL_LD;
            OP_ST:                         opc_class = CL_ST;
            OP_BR:                         opc_class = CL_BR;
            OP_JR:                         opc_class = CL_JR;
            OP_MFHI:                       opc_class = CL_MFHI;
            OP_MFLO:                       opc_class = CL_MFLO;
            OP_IN:                         opc_class = CL_IN;
            OP_OUT:                        opc_class = CL_OUT;
            OP_HALT:                       opc_class = CL_HALT;
            default:                       opc_class = CL_NOP;
        endcase
    endfunction

    // Final execute step of each class.
    function automatic state_t last_step(input iclass_t c);
        case (c)
            CL_ALU, CL_IMM, CL_LDI: last_step = T5;
            CL_MULDIV, CL_BR:       last_step = T6;
            CL_LD, CL_ST:           last_step = T7;
            default:                last_step = T3;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational strobe decode: (state, instruction class, CON_FF) -> strobes.
// Each step drives at most one bus source.
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t  state,
    input  iclass_t iclass,
    input  logic    con_ff,
    output ctrl_t   ctrl
);

    // Moore decode of the registered step and the latched class
    always_comb begin
        ctrl = '0;
        case (state)
            RESET_S: ctrl.clear = 1'b1;
            T0: begin
                ctrl.run = 1'b1; ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1;
            end
            T1: begin
                ctrl.run = 1'b1; ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
            end
            T2: begin
                ctrl.run = 1'b1; ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1;
                ctrl.pc_in = 1'b1; ctrl.inc_pc = 1'b1;
            end
            T3: begin
                ctrl.run = 1'b1;
                case (iclass)
                    CL_ALU, CL_IMM: begin ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1; end
                    CL_LDI, CL_LD, CL_ST: begin ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1; end
                    CL_MULDIV: begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1; end
                    CL_BR:     begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.con_in = 1'b1; end
                    CL_JR:     begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.pc_in = 1'b1; end
                    CL_MFHI:   begin ctrl.hi_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
                    CL_MFLO:   begin ctrl.lo_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
                    CL_IN:     begin ctrl.inport_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
                    CL_OUT:    begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.outport_in = 1'b1; end
                    default: ;
                endcase
            end
            T4: begin
                ctrl.run = 1'b1;
                case (iclass)
                    CL_ALU:    begin ctrl.grc = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1; end
                    CL_IMM, CL_LDI, CL_LD, CL_ST: begin ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; end
                    CL_MULDIV: begin ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1; end
                    CL_BR:     begin ctrl.pc_out = 1'b1; ctrl.y_in = 1'b1; end
                    default: ;
                endcase
            end
            T5: begin
                ctrl.run = 1'b1;
                case (iclass)
                    CL_ALU, CL_IMM, CL_LDI: begin ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
                    CL_MULDIV:    begin ctrl.zlow_out = 1'b1; ctrl.lo_in = 1'b1; end
                    CL_LD, CL_ST: begin ctrl.zlow_out = 1'b1; ctrl.mar_in = 1'b1; end
                    CL_BR:        begin ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; end
                    default: ;
                endcase
            end
            T6: begin
                ctrl.run = 1'b1;
                case (iclass)
                    CL_MULDIV: begin ctrl.zhigh_out = 1'b1; ctrl.hi_in = 1'b1; end
                    CL_LD:     begin ctrl.read = 1'b1; ctrl.mdr_in = 1'b1; end
                    CL_ST:     begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.mdr_in = 1'b1; end
                    // Branch target is always on the bus; only the load is conditional.
                    CL_BR:     begin ctrl.zlow_out = 1'b1; ctrl.pc_in = con_ff; end
                    default: ;
                endcase
            end
            T7: begin
                ctrl.run = 1'b1;
                case (iclass)
                    CL_LD:   begin ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
                    CL_ST:   ctrl.write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired mini-SRC sequencer: fetch T0-T2, per-class execute T3-T7,
// sticky Stop request, HALT until reset. State is exposed on dbg_state.
module control_unit
    import cpu_ctrl_pkg::*;
(
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Stop,
    input  logic [31:0]        IR,
    input  logic               CON_FF,
    output logic               Run,
    output logic               PCout,
    output logic               Zhighout,
    output logic               Zlowout,
    output logic               MDRout,
    output logic               HIout,
    output logic               LOout,
    output logic               InPortout,
    output logic               Cout,
    output logic               BAout,
    output logic               PCin,
    output logic               Zin,
    output logic               MDRin,
    output logic               MARin,
    output logic               Yin,
    output logic               HIin,
    output logic               LOin,
    output logic               IRin,
    output logic               OutPortin,
    output logic               CONin,
    output logic               Gra,
    output logic               Grb,
    output logic               Grc,
    output logic               Rin,
    output logic               Rout,
    output logic               IncPC,
    output logic               Read,
    output logic               Write,
    output logic               Clear,
    output logic [NSTEP_W-1:0] dbg_state
);

    state_t           state_q, state_d;
    logic [OPC_W-1:0] opc_q, opc_d;
    logic             stop_q, stop_d;
    iclass_t          iclass;
    ctrl_t            ctrl;
    logic             in_instr;
    logic             unused_ir;

    // Only the opcode field of IR is consumed here.
    assign unused_ir = ^IR[26:0];
    assign iclass    = opc_class(opc_q);
    assign in_instr  = (state_q != RESET_S) && (state_q != HALT);

    // Next step, opcode latch at T3 entry, and sticky stop request
    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        stop_d  = stop_q | (Stop & in_instr);
        case (state_q)
            RESET_S: state_d = T0;
            T0:      state_d = T1;
            T1:      state_d = T2;
            T2: begin
                state_d = T3;
                opc_d   = IR[31:27];
            end
            T3, T4, T5, T6, T7: begin
                if (state_q == last_step(iclass)) begin
                    state_d = (iclass == CL_HALT || stop_q || Stop) ? HALT : T0;
                end else begin
                    state_d = state_t'(state_q + 4'd1);
                end
            end
            default: state_d = HALT;
        endcase
    end

    // State, opcode and stop registers with synchronous active-low reset
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= RESET_S;
            opc_q   <= '0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            stop_q  <= stop_d;
        end
    end

    ctrl_decode u_decode (
        .state  (state_q),
        .iclass (iclass),
        .con_ff (CON_FF),
        .ctrl   (ctrl)
    );

    assign dbg_state = state_q;
    assign Run       = ctrl.run;
    assign Clear     = ctrl.clear;
    assign PCout     = ctrl.pc_out;
    assign Zhighout  = ctrl.zhigh_out;
    assign Zlowout   = ctrl.zlow_out;
    assign MDRout    = ctrl.mdr_out;
    assign HIout     = ctrl.hi_out;
    assign LOout     = ctrl.lo_out;
    assign InPortout = ctrl.inport_out;
    assign Cout      = ctrl.c_out;
    assign BAout     = ctrl.ba_out;
    assign PCin      = ctrl.pc_in;
    assign Zin       = ctrl.z_in;
    assign MDRin     = ctrl.mdr_in;
    assign MARin     = ctrl.mar_in;
    assign Yin       = ctrl.y_in;
    assign HIin      = ctrl.hi_in;
    assign LOin      = ctrl.lo_in;
    assign IRin      = ctrl.ir_in;
    assign OutPortin = ctrl.outport_in;
    assign CONin     = ctrl.con_in;
    assign Gra       = ctrl.gra;
    assign Grb       = ctrl.grb;
    assign Grc       = ctrl.grc;
    assign Rin       = ctrl.r_in;
    assign Rout      = ctrl.r_out;
    assign IncPC     = ctrl.inc_pc;
    assign Read      = ctrl.read;
    assign Write     = ctrl.write;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-instruction expected strobe sequences are
// queued by the driver and checked cycle by cycle on the falling edge.
module tb_control_unit;
    import cpu_ctrl_pkg::*;

    localparam logic [28:0] B_RUN      = 29'd1 << 28;
    localparam logic [28:0] B_CLEAR    = 29'd1 << 27;
    localparam logic [28:0] B_PCOUT    = 29'd1 << 26;
    localparam logic [28:0] B_ZHIGHOUT = 29'd1 << 25;
    localparam logic [28:0] B_ZLOWOUT  = 29'd1 << 24;
    localparam logic [28:0] B_MDROUT   = 29'd1 << 23;
    localparam logic [28:0] B_HIOUT    = 29'd1 << 22;
    localparam logic [28:0] B_LOOUT    = 29'd1 << 21;
    localparam logic [28:0] B_INPOUT   = 29'd1 << 20;
    localparam logic [28:0] B_COUT     = 29'd1 << 19;
    localparam logic [28:0] B_BAOUT    = 29'd1 << 18;
    localparam logic [28:0] B_PCIN     = 29'd1 << 17;
    localparam logic [28:0] B_ZIN      = 29'd1 << 16;
    localparam logic [28:0] B_MDRIN    = 29'd1 << 15;
    localparam logic [28:0] B_MARIN    = 29'd1 << 14;
    localparam logic [28:0] B_YIN      = 29'd1 << 13;
    localparam logic [28:0] B_HIIN     = 29'd1 << 12;
    localparam logic [28:0] B_LOIN     = 29'd1 << 11;
    localparam logic [28:0] B_IRIN     = 29'd1 << 10;
    localparam logic [28:0] B_OUTPIN   = 29'd1 << 9;
    localparam logic [28:0] B_CONIN    = 29'd1 << 8;
    localparam logic [28:0] B_GRA      = 29'd1 << 7;
    localparam logic [28:0] B_GRB      = 29'd1 << 6;
    localparam logic [28:0] B_GRC      = 29'd1 << 5;
    localparam logic [28:0] B_RIN      = 29'd1 << 4;
    localparam logic [28:0] B_ROUT     = 29'd1 << 3;
    localparam logic [28:0] B_INCPC    = 29'd1 << 2;
    localparam logic [28:0] B_READ     = 29'd1 << 1;
    localparam logic [28:0] B_WRITE    = 29'd1;
    localparam logic [28:0] BUS_MASK   = B_PCOUT | B_ZHIGHOUT | B_ZLOWOUT | B_MDROUT | B_HIOUT
                                       | B_LOOUT | B_INPOUT | B_COUT | B_BAOUT;

    logic        Clock, Reset, Stop, CON_FF;
    logic [31:0] IR;
    logic Run, PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout;
    logic PCin, Zin, MDRin, MARin, Yin, HIin, LOin, IRin, OutPortin, CONin;
    logic Gra, Grb, Grc, Rin, Rout, IncPC, Read, Write, Clear;
    logic [NSTEP_W-1:0] dbg_state;
    logic [28:0] obs;

    logic [28:0] exp_q[$];
    logic [28:0] model_seq[$];
    logic [28:0] probe_v;
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    control_unit dut (
        .Clock(Clock), .Reset(Reset), .Stop(Stop), .IR(IR), .CON_FF(CON_FF),
        .Run(Run), .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .MDRout(MDRout), .HIout(HIout), .LOout(LOout), .InPortout(InPortout),
        .Cout(Cout), .BAout(BAout), .PCin(PCin), .Zin(Zin), .MDRin(MDRin),
        .MARin(MARin), .Yin(Yin), .HIin(HIin), .LOin(LOin), .IRin(IRin),
        .OutPortin(OutPortin), .CONin(CONin), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .Rin(Rin), .Rout(Rout), .IncPC(IncPC), .Read(Read), .Write(Write),
        .Clear(Clear), .dbg_state(dbg_state)
    );

    assign obs = {Run, Clear, PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout,
                  Cout, BAout, PCin, Zin, MDRin, MARin, Yin, HIin, LOin, IRin, OutPortin,
                  CONin, Gra, Grb, Grc, Rin, Rout, IncPC, Read, Write};

    // Clock / reset block
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Behavioural model: the full strobe sequence of one instruction
    task automatic model_build(input logic [4:0] opc, input logic con);
        model_seq.delete();
        model_seq.push_back(B_RUN | B_PCOUT | B_MARIN);
        model_seq.push_back(B_RUN | B_READ | B_MDRIN);
        model_seq.push_back(B_RUN | B_MDROUT | B_IRIN | B_PCIN | B_INCPC);
        case (opc)
            5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
                model_seq.push_back(B_RUN | B_GRB | B_ROUT | B_YIN);
                model_seq.push_back(B_RUN | B_GRC | B_ROUT | B_ZIN);
                model_seq.push_back(B_RUN | B_ZLOWOUT | B_GRA | B_RIN);
            end
            5'b01100, 5'b01101, 5'b01110, 5'b00001: begin
                model_seq.push_back(B_RUN | B_GRB | B_YIN | ((opc == 5'b00001) ? B_BAOUT : B_ROUT));
                model_seq.push_back(B_RUN | B_COUT | B_ZIN);
                model_seq.push_back(B_RUN | B_ZLOWOUT | B_GRA | B_RIN);
            end
            5'b01111, 5'b10000: begin
                model_seq.push_back(B_RUN | B_GRA | B_ROUT | B_YIN);
                model_seq.push_back(B_RUN | B_GRB | B_ROUT | B_ZIN);
                model_seq.push_back(B_RUN | B_ZLOWOUT | B_LOIN);
                model_seq.push_back(B_RUN | B_ZHIGHOUT | B_HIIN);
            end
            5'b00000, 5'b00010: begin
                model_seq.push_back(B_RUN | B_GRB | B_BAOUT | B_YIN);
                model_seq.push_back(B_RUN | B_COUT | B_ZIN);
                model_seq.push_back(B_RUN | B_ZLOWOUT | B_MARIN);
                if (opc == 5'b00000) begin
                    model_seq.push_back(B_RUN | B_READ | B_MDRIN);
                    model_seq.push_back(B_RUN | B_MDROUT | B_GRA | B_RIN);
                end else begin
                    model_seq.push_back(B_RUN | B_GRA | B_ROUT | B_MDRIN);
                    model_seq.push_back(B_RUN | B_WRITE);
                end
            end
            5'b10010: begin
                model_seq.push_back(B_RUN | B_GRA | B_ROUT | B_CONIN);
                model_seq.push_back(B_RUN | B_PCOUT | B_YIN);
                model_seq.push_back(B_RUN | B_COUT | B_ZIN);
                model_seq.push_back(B_RUN | B_ZLOWOUT | (con ? B_PCIN : 29'd0));
            end
            5'b10011: model_seq.push_back(B_RUN | B_GRA | B_ROUT | B_PCIN);
            5'b11001: model_seq.push_back(B_RUN | B_HIOUT | B_GRA | B_RIN);
            5'b11000: model_seq.push_back(B_RUN | B_LOOUT | B_GRA | B_RIN);
            5'b10110: model_seq.push_back(B_RUN | B_INPOUT | B_GRA | B_RIN);
            5'b10111: model_seq.push_back(B_RUN | B_GRA | B_ROUT | B_OUTPIN);
            default:  model_seq.push_back(B_RUN);
        endcase
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    // Driver: hold Reset low for n cycles, each expecting Clear only
    task automatic do_reset(input int n);
        Reset = 1'b0;
        Stop  = 1'b0;
        repeat (n) begin
            @(posedge Clock); #1;
            exp_q.push_back(B_CLEAR);
        end
        Reset = 1'b1;
    endtask

    // Driver: HALT cycles, every output low
    task automatic halt_cycles(input int n);
        repeat (n) begin
            @(posedge Clock); #1;
            exp_q.push_back(29'd0);
        end
    endtask

    // Driver: one instruction from T0; optional Stop pulse, reset point and probe
    task automatic run_instr(input logic [4:0] opc, input logic con,
                             input int stop_idx, input int rst_idx, input int probe_idx);
        logic [31:0] r;
        r = $urandom();
        model_build(opc, con);
        for (int i = 0; i < model_seq.size(); i++) begin
            @(posedge Clock); #1;
            // After the latch edge IR is scrambled: outputs must not follow it.
            IR     = (i < 3) ? {opc, r[26:0]} : $urandom();
            CON_FF = con;
            Stop   = (i == stop_idx);
            exp_q.push_back(model_seq[i]);
            if (i == probe_idx) begin
                #1 probe_v = obs;
            end
            if (i == rst_idx) begin
                do_reset(1);
                return;
            end
        end
        Stop = 1'b0;
    endtask

    // Scoreboard: compare every queued cycle and check the bus-source invariant
    always @(negedge Clock) begin
        logic [28:0] e;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL strobes cyc=%0d got=%b want=%b", cyc, obs, e);
            end
            n_cmp++;
            if ($countones(obs & BUS_MASK) > 1) begin
                n_bad++;
                $display("FAIL bus_onehot cyc=%0d got=%b want<=1 source", cyc, obs & BUS_MASK);
            end
        end
    end

    initial begin
        IR = 32'd0; CON_FF = 1'b0; Stop = 1'b0; Reset = 1'b0;

        // Pin the model with hand-counted sequence lengths and steps
        model_build(5'b01100, 1'b0);
        lit("model_addi_len", model_seq.size(), 6);
        model_build(5'b00000, 1'b0);
        lit("model_ld_len", model_seq.size(), 8);
        lit("model_ld_t7", {3'd0, model_seq[7]}, {3'd0, B_RUN | B_MDROUT | B_GRA | B_RIN});
        model_build(5'b01111, 1'b0);
        lit("model_mul_len", model_seq.size(), 7);
        model_build(5'b10011, 1'b0);
        lit("model_jr_len", model_seq.size(), 4);

        do_reset(2);
        lit("reset_state", {28'd0, dbg_state}, 32'(RESET_S));

        run_instr(5'b01100, 1'b0, -1, -1, 0);
        lit("first_t0", {3'd0, probe_v}, {3'd0, B_RUN | B_PCOUT | B_MARIN});
        run_instr(5'b00000, 1'b0, -1, -1, 6);
        lit("ld_t6_read", {3'd0, probe_v}, {3'd0, B_RUN | B_READ | B_MDRIN});
        run_instr(5'b10010, 1'b1, -1, -1, 6);
        lit("br_taken_t6", {3'd0, probe_v}, {3'd0, B_RUN | B_ZLOWOUT | B_PCIN});
        run_instr(5'b10010, 1'b0, -1, -1, 6);
        lit("br_not_taken_t6", {3'd0, probe_v}, {3'd0, B_RUN | B_ZLOWOUT});

        run_instr(5'b00100, 1'b0, -1, -1, -1);
        run_instr(5'b01101, 1'b1, -1, -1, -1);
        run_instr(5'b00001, 1'b0, -1, -1, -1);
        run_instr(5'b10000, 1'b0, -1, -1, -1);
        run_instr(5'b00010, 1'b0, -1, -1, -1);
        run_instr(5'b10011, 1'b0, -1, -1, -1);
        run_instr(5'b11001, 1'b0, -1, -1, -1);
        run_instr(5'b11000, 1'b0, -1, -1, -1);
        run_instr(5'b10110, 1'b0, -1, -1, -1);
        run_instr(5'b10111, 1'b0, -1, -1, -1);
        run_instr(5'b11010, 1'b0, -1, -1, -1);
        run_instr(5'b11111, 1'b0, -1, -1, -1);

        // halt opcode stops the sequencer until reset
        run_instr(5'b11011, 1'b0, -1, -1, -1);
        halt_cycles(3);
        do_reset(1);

        // Reset during T5 of st abandons it before Write
        run_instr(5'b00010, 1'b0, -1, 5, -1);
        lit("st_abort_state", {28'd0, dbg_state}, 32'(RESET_S));
        run_instr(5'b00110, 1'b0, -1, -1, -1);

        // Stop pulsed in T4 of add: finish T5, then HALT for good
        run_instr(5'b00011, 1'b0, 4, -1, -1);
        halt_cycles(11);
        lit("stop_halt_state", {28'd0, dbg_state}, 32'(HALT));

        @(negedge Clock); #1;
        lit("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
